// File: rtl/mnist_seg_model.sv
// MNIST segmentation bring-up model: threshold -> {one-hot class, fg}, LATENCY-stage elastic pipe, 1 beat/clk,
// ready ripples back combinationally from m_axi4s_tready. Define MNIST_SEG_MODEL_CLASS_ROTATE_EN to rotate class per frame.
module mnist_seg_model #(
  parameter int TUSER_WIDTH     = 1,
  parameter int S_TDATA_WIDTH   = 8,
  parameter int NUM_CLASS       = 10,
  parameter int M_TDATA_WIDTH   = NUM_CLASS + 1,
  parameter int LATENCY         = 4,
  parameter int IMG_X_WIDTH     = 10,
  parameter int IMG_Y_WIDTH     = 9,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [S_TDATA_WIDTH-1:0]   param_threshold,
  input  logic [3:0]                 param_class,
  input  logic [IMG_X_WIDTH-1:0]     param_width,
  input  logic [TUSER_WIDTH-1:0]     s_axi4s_tuser,
  input  logic                       s_axi4s_tlast,
  input  logic [S_TDATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                       s_axi4s_tvalid,
  output logic                       s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]     m_axi4s_tuser,
  output logic                       m_axi4s_tlast,
  output logic [M_TDATA_WIDTH-1:0]   m_axi4s_tdata,
  output logic                       m_axi4s_tvalid,
  input  logic                       m_axi4s_tready,
  output logic [FRAME_CNT_WIDTH-1:0] status_frame_count,
  output logic [IMG_Y_WIDTH-1:0]     status_y,
  output logic                       status_line_err
);

  localparam int XW1 = IMG_X_WIDTH + 1;

  logic [LATENCY-1:0]       r_vld;
  logic [LATENCY-1:0]       r_last;
  logic [M_TDATA_WIDTH-1:0] r_dat  [LATENCY];
  logic [TUSER_WIDTH-1:0]   r_user [LATENCY];
  logic [LATENCY-1:0]       w_ld;
  logic                     w_acc;
  logic                     w_fg;
  logic [3:0]               w_class_sel;
  logic [M_TDATA_WIDTH-1:0] w_map;

  logic [IMG_X_WIDTH-1:0]     r_x;
  logic [IMG_Y_WIDTH-1:0]     r_y;
  logic [FRAME_CNT_WIDTH-1:0] r_frame;
  logic                       r_err;
  logic [IMG_X_WIDTH-1:0]     w_x_base;
  logic [IMG_Y_WIDTH-1:0]     w_y_base;
  logic [XW1-1:0]             w_len;

  // Stage k may load when any stage at or after it holds a bubble, or the sink takes a beat.
  always_comb begin
    for (int k = 0; k < LATENCY; k++) begin
      w_ld[k] = m_axi4s_tready;
      for (int j = k; j < LATENCY; j++) begin
        if (!r_vld[j]) w_ld[k] = 1'b1;
      end
    end
  end

  assign w_acc          = s_axi4s_tvalid && w_ld[0];
  assign s_axi4s_tready = w_ld[0];

`ifdef MNIST_SEG_MODEL_CLASS_ROTATE_EN
  logic [3:0] r_class;
  logic [3:0] w_class_nxt;
  logic       w_unused_class;

  assign w_unused_class = ^param_class;

  // The start-of-frame beat is mapped with the class it advances to.
  always_comb begin
    w_class_nxt = r_class;
    if (s_axi4s_tuser[0]) begin
      w_class_nxt = (r_class == 4'(NUM_CLASS - 1)) ? 4'd0 : r_class + 4'd1;
    end
  end

  assign w_class_sel = w_class_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_class <= 4'd0;
    end else if (w_acc) begin
      r_class <= w_class_nxt;
    end
  end
`else
  assign w_class_sel = param_class;
`endif

  always_comb begin
    w_fg     = (s_axi4s_tdata >= param_threshold);
    w_map    = '0;
    w_map[0] = w_fg;
    for (int c = 0; c < NUM_CLASS; c++) begin
      w_map[1+c] = w_fg && (w_class_sel == 4'(c));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld  <= '0;
      r_last <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_dat[k]  <= '0;
        r_user[k] <= '0;
      end
    end else begin
      if (w_ld[0]) begin
        r_vld[0]  <= s_axi4s_tvalid;
        r_dat[0]  <= w_map;
        r_user[0] <= s_axi4s_tuser;
        r_last[0] <= s_axi4s_tlast;
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (w_ld[k]) begin
          r_vld[k]  <= r_vld[k-1];
          r_dat[k]  <= r_dat[k-1];
          r_user[k] <= r_user[k-1];
          r_last[k] <= r_last[k-1];
        end
      end
    end
  end

  assign m_axi4s_tvalid = r_vld[LATENCY-1];
  assign m_axi4s_tdata  = r_dat[LATENCY-1];
  assign m_axi4s_tuser  = r_user[LATENCY-1];
  assign m_axi4s_tlast  = r_last[LATENCY-1];

  // Frame start rebases position before the line-length check on the same beat.
  always_comb begin
    w_x_base = s_axi4s_tuser[0] ? '0 : r_x;
    w_y_base = s_axi4s_tuser[0] ? '0 : r_y;
    w_len    = {1'b0, w_x_base} + XW1'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_frame <= '0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      if (s_axi4s_tuser[0]) r_frame <= r_frame + FRAME_CNT_WIDTH'(1);
      if (s_axi4s_tlast) begin
        if (w_len != {1'b0, param_width}) r_err <= 1'b1;
        r_x <= '0;
        r_y <= (&w_y_base) ? w_y_base : w_y_base + IMG_Y_WIDTH'(1);
      end else begin
        r_x <= (&w_x_base) ? w_x_base : w_x_base + IMG_X_WIDTH'(1);
        r_y <= w_y_base;
      end
    end
  end

  assign status_frame_count = r_frame;
  assign status_y           = r_y;
  assign status_line_err    = r_err;

endmodule

// File: tb/tb_mnist_seg_model.sv
// Randomized bench for mnist_seg_model against a queue-based behavioural model.
module tb_mnist_seg_model;
  localparam int LAT = 4, NC = 10, MW = 11, SW = 8, XW = 10, YW = 9, FW = 2;
`ifdef MNIST_SEG_MODEL_CLASS_ROTATE_EN
  localparam logic [MW-1:0] LIT128 = 11'h005;
`else
  localparam logic [MW-1:0] LIT128 = 11'h011;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [SW-1:0] param_threshold;
  logic [3:0]    param_class;
  logic [XW-1:0] param_width;
  logic [0:0]    s_tuser;
  logic          s_tlast, s_tvalid, s_tready;
  logic [SW-1:0] s_tdata;
  logic [0:0]    m_tuser;
  logic          m_tlast, m_tvalid, m_tready;
  logic [MW-1:0] m_tdata;
  logic [FW-1:0] st_frame;
  logic [YW-1:0] st_y;
  logic          st_err;

  mnist_seg_model #(.FRAME_CNT_WIDTH(FW)) dut (
    .clk(clk), .reset_n(reset_n),
    .param_threshold(param_threshold), .param_class(param_class), .param_width(param_width),
    .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
    .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
    .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tdata(m_tdata),
    .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready),
    .status_frame_count(st_frame), .status_y(st_y), .status_line_err(st_err)
  );

  typedef struct {
    logic [MW-1:0] dat;
    logic          usr;
    logic          lst;
    int            acc;
    int            pix;
  } ent_t;

  ent_t q[$];
  ent_t e_pop, e_new;
  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int rdy_pct = 100;
  int m_fc = 0, m_x = 0, m_y = 0, m_class = 0, cls = 0;
  logic m_err = 1'b0;
  bit exact_lat = 0, lit_chk = 0, rot_chk = 0;
  int rot_idx = 0;
  logic prev_stall = 1'b0;
  logic [MW-1:0] prev_dat;
  logic prev_usr, prev_lst;
  logic [MW-1:0] rot_tab [12] = '{11'h005, 11'h009, 11'h011, 11'h021, 11'h041, 11'h081,
                                   11'h101, 11'h201, 11'h401, 11'h003, 11'h005, 11'h009};
  int fc_tab [5] = '{1, 2, 3, 0, 1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] expect_word(input int pix, input int thr, input int c);
    if (pix < thr) return '0;
    if (c < NC) return MW'(1) | (MW'(1) << (c + 1));
    return MW'(1);
  endfunction

  always @(posedge clk) cyc++;

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_tready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Compare process: status, handshake rules, ordering and stall stability each cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("frame_count", st_frame, m_fc);
      chk("status_y", st_y, m_y);
      chk("line_err", st_err, m_err);
      chk("s_tready", s_tready, (q.size() < LAT) || m_tready);
      if (q.size() == 0) chk("idle_tvalid", m_tvalid, 0);
      if (prev_stall) begin
        chk("stall_tvalid", m_tvalid, 1);
        chk("stall_tdata", m_tdata, prev_dat);
        chk("stall_tuser", m_tuser, prev_usr);
        chk("stall_tlast", m_tlast, prev_lst);
      end
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) begin
          chk("spurious_beat", 1, 0);
        end else begin
          e_pop = q.pop_front();
          chk("tdata", m_tdata, e_pop.dat);
          chk("tuser", m_tuser, e_pop.usr);
          chk("tlast", m_tlast, e_pop.lst);
          if (exact_lat) chk("latency", cyc - e_pop.acc, LAT);
          if (lit_chk && e_pop.pix == 127) chk("px127", m_tdata, 11'h000);
          if (lit_chk && e_pop.pix == 128) chk("px128", m_tdata, LIT128);
`ifdef MNIST_SEG_MODEL_CLASS_ROTATE_EN
          if (rot_chk && e_pop.usr && rot_idx < 12) begin
            chk("rot_frame", m_tdata, rot_tab[rot_idx]);
            rot_idx++;
          end
`endif
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_dat   = m_tdata;
      prev_usr   = m_tuser[0];
      prev_lst   = m_tlast;
      if (s_tvalid && s_tready) begin
        if (s_tuser[0]) begin
          m_fc = (m_fc + 1) % (1 << FW);
          m_x = 0;
          m_y = 0;
          m_class = (m_class + 1) % NC;
        end
`ifdef MNIST_SEG_MODEL_CLASS_ROTATE_EN
        cls = m_class;
`else
        cls = int'(param_class);
`endif
        e_new.dat = expect_word(int'(s_tdata), int'(param_threshold), cls);
        e_new.usr = s_tuser[0];
        e_new.lst = s_tlast;
        e_new.acc = cyc;
        e_new.pix = int'(s_tdata);
        q.push_back(e_new);
        if (s_tlast) begin
          if (m_x + 1 != int'(param_width)) m_err = 1'b1;
          m_x = 0;
          if (m_y < (1 << YW) - 1) m_y++;
        end else if (m_x < (1 << XW) - 1) begin
          m_x++;
        end
      end
    end
  end

  task automatic send(input int pix, input bit usr, input bit lst);
    bit r;
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = SW'(pix);
    s_tuser  = usr;
    s_tlast  = lst;
    forever begin
      @(negedge clk);
      r = s_tready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 5000) begin
        chk("send_timeout", n, 0);
        break;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_line(input int len, input bit sof, input int mode, input int gap_pct);
    for (int i = 0; i < len; i++) begin
      int pix;
      if (mode == 0) pix = $urandom_range(0, 255);
      else if (mode == 1) pix = 255;
      else pix = i;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        @(posedge clk);
        #1;
      end
      send(pix, sof && (i == 0), i == len - 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    q.delete();
    m_fc = 0; m_x = 0; m_y = 0; m_class = 0; m_err = 1'b0;
    prev_stall = 1'b0;
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_frame", st_frame, 0);
    chk("rst_y", st_y, 0);
    chk("rst_err", st_err, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; s_tlast = 1'b0;
    param_threshold = 8'd128; param_class = 4'd3; param_width = 10'd256;
    repeat (3) @(posedge clk);
    #1;
    chk("init_tvalid", m_tvalid, 0);
    chk("init_tdata", m_tdata, 0);
    chk("init_frame", st_frame, 0);
    chk("init_y", st_y, 0);
    chk("init_err", st_err, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp 0..255 at full rate: exact latency and the threshold edge.
    exact_lat = 1; lit_chk = 1;
    send_line(256, 1, 2, 0);
    drain();
    exact_lat = 0; lit_chk = 0;
    chk("ramp_frame", st_frame, 1);
    chk("ramp_y", st_y, 1);
    chk("ramp_err", st_err, 0);

    // Random 640x4 frame under 30% sink duty, random params including out-of-range class.
    rdy_pct = 30;
    param_threshold = SW'($urandom_range(1, 255));
    param_class = 4'($urandom_range(0, 15));
    param_width = 10'd640;
    send_line(640, 1, 0, 10);
    for (int l = 1; l < 4; l++) send_line(640, 0, 0, 10);
    drain();
    param_class = 4'd15;
    param_width = 10'd8;
    send_line(8, 1, 1, 20);
    drain();
    rdy_pct = 100;

    // Line length check: 640, 639, 640.
    param_threshold = 8'd128; param_class = 4'd3; param_width = 10'd640;
    send_line(640, 1, 0, 0);
    drain();
    chk("line1_err", st_err, 0);
    send_line(639, 0, 0, 0);
    drain();
    chk("line2_err", st_err, 1);
    send_line(640, 0, 0, 0);
    drain();
    chk("line3_err", st_err, 1);
    chk("line3_y", st_y, 3);

    // Reset with beats in flight and the sink stalled.
    rdy_pct = 0;
    @(posedge clk);
    #1;
    param_width = 10'd4;
    send(200, 1, 0);
    send(10, 0, 0);
    send(150, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("inflight_tvalid", m_tvalid, 1);
    do_reset();
    rdy_pct = 100;
    @(posedge clk);
    #1;

    // Five frames of two 4-pixel lines: frame counter wraps at 2 bits.
    for (int f = 0; f < 5; f++) begin
      send_line(4, 1, 0, 0);
      send_line(4, 0, 0, 0);
      drain();
      chk("fc_frame", st_frame, fc_tab[f]);
      chk("fc_y", st_y, 2);
      chk("fc_err", st_err, 0);
    end

    // Twelve all-255 frames from reset: class sequence per frame.
    do_reset();
    @(posedge clk);
    #1;
    rot_chk = 1;
    for (int f = 0; f < 12; f++) begin
      param_class = 4'(f);
      send_line(4, 1, 1, 0);
    end
    drain();
    rot_chk = 0;
`ifdef MNIST_SEG_MODEL_CLASS_ROTATE_EN
    chk("rot_count", rot_idx, 12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mnist_seg_model.md
Name: mnist_seg_model

Overview:
- Cycle-accurate simulation and bring-up model of the MNIST segmentation core.
- Replaces a pure passthrough stub with a parametrised elastic pipeline of configurable latency.
- Thresholds multi-bit input pixels to foreground and emits a {class one-hot, foreground} word per pixel.
- Tracks frame and line position and flags malformed lines, so downstream DMA and overlay logic see realistic timing and backpressure.

Parameters:
- TUSER_WIDTH, 1, sideband width; bit 0 is start-of-frame.
- S_TDATA_WIDTH, 8, input pixel width.
- NUM_CLASS, 10, number of classes.
- M_TDATA_WIDTH, NUM_CLASS+1, output width; must equal NUM_CLASS+1.
- LATENCY, 4, pipeline stages, 1..16.
- IMG_X_WIDTH, 10, x counter width.
- IMG_Y_WIDTH, 9, y counter width.
- FRAME_CNT_WIDTH, 16, frame counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- param_threshold  in  S_TDATA_WIDTH  foreground threshold
- param_class  in  4  class index for foreground pixels
- param_width  in  IMG_X_WIDTH  expected pixels per line
- s_axi4s_tuser  in  TUSER_WIDTH  input sideband
- s_axi4s_tlast  in  1  end of line
- s_axi4s_tdata  in  S_TDATA_WIDTH  pixel
- s_axi4s_tvalid  in  1  valid
- s_axi4s_tready  out  1  ready
- m_axi4s_tuser  out  TUSER_WIDTH  delayed sideband
- m_axi4s_tlast  out  1  delayed end of line
- m_axi4s_tdata  out  M_TDATA_WIDTH  {one-hot class, fg}
- m_axi4s_tvalid  out  1  valid
- m_axi4s_tready  in  1  ready
- status_frame_count  out  FRAME_CNT_WIDTH  frames started at input
- status_y  out  IMG_Y_WIDTH  current input line
- status_line_err  out  1  sticky malformed-line flag

Behaviour:
- Reset (reset_n low, async):
  - All stage valids clear. m_axi4s_tvalid=0, m_axi4s_tuser=0, m_axi4s_tlast=0, m_axi4s_tdata=0.
  - status_frame_count=0, status_y=0, status_line_err=0, x counter=0.
  - Release is synchronous to clk. Reset mid-stream drops all in-flight beats.
- Pipeline:
  - LATENCY registered stages. Stage k loads when its valid=0 or stage k+1 accepts; the last stage's next is m_axi4s_tready.
  - s_axi4s_tready = !valid[0] || stage0 advancing. This is combinational from m_axi4s_tready through the chain; no bubbles.
  - Throughput is 1 beat/clk when m_axi4s_tready is held 1.
  - Latency from input accept to m_axi4s_tvalid is exactly LATENCY cycles with no stall.
  - Beats are never dropped or duplicated. Outputs stay stable while tvalid=1 and tready=0.
- Data mapping (computed in stage 0):
  - fg = (s_axi4s_tdata >= param_threshold), unsigned compare.
  - tdata[0] = fg.
  - tdata[1+c] = fg && (c == class_sel); bits are all zero when fg=0.
  - If class_sel >= NUM_CLASS, tdata[M-1:1] = 0.
  - tuser and tlast pass through unchanged.
- Position tracking (on input handshake only):
  - tuser[0]=1: status_frame_count += 1 (wraps modulo 2^FRAME_CNT_WIDTH), y=0, and this beat counts as x=0.
  - tlast=1: if x+1 != param_width, set status_line_err. Then x=0 and y += 1, saturating at all-ones.
  - Otherwise x += 1, saturating.
  - tuser and tlast on the same beat: apply the frame start first, then the line end check with x=0.
  - status_line_err clears only on reset.
- The param_* inputs are sampled at stage 0 per beat. They must be quasi-static; changes take effect on the next accepted beat.

Optional Feature:
- Macro: MNIST_SEG_MODEL_CLASS_ROTATE_EN.
- Defined: class_sel = internal 4-bit register.
  - Reset value 0.
  - Increments on each input beat with tuser[0]=1, wrapping from NUM_CLASS-1 to 0.
  - Updated before that beat is mapped, so frame 1 uses class 1.
  - param_class is ignored.
- Undefined: class_sel = param_class; no rotation register exists.

Test Plan:
- Throughput/latency:
  - Stimulus: LATENCY=4, m_tready=1, 8-bit pixels 0..255 streamed, threshold=128, class=3.
  - Required: first m_tvalid 4 cycles after first accept. Pixel 127 gives 0x000; pixel 128 gives 0x011; one output/clk.
- Backpressure:
  - Stimulus: random m_tready at 30% duty, 640x4 frame.
  - Required: output sequence identical to input order; data, tuser and tlast stable while stalled; s_tready=0 once all 4 stages are full.
- Line check:
  - Stimulus: param_width=640, lines of 640, 639, 640 pixels.
  - Required: status_line_err rises after the second tlast and stays 1; status_y=3.
- Frame counter:
  - Stimulus: 3 frames of 2 lines each, FRAME_CNT_WIDTH=2, then 2 more frames.
  - Required: frame_count 1, 2, 3, then wraps to 0, then 1; y resets to 0 on each tuser.
- Reset mid-stream:
  - Stimulus: deassert reset_n with 3 beats in flight, m_tready=0.
  - Required: m_tvalid=0 immediately (async); all counters 0; the next frame passes cleanly.
- Rotate (macro defined):
  - Stimulus: 12 frames of all-255 pixels.
  - Required: frame classes are 1, 2, …, 9, 0, 1, 2, giving tdata 0x005, 0x009, …, 0x401, 0x003, 0x005, 0x009.
